vjtag_dr_bank: RTL and testbench

//  Parametrised data-register bank behind the virtual JTAG hub node.
//  - Decodes ir_in to select one of NUM_CH shift registers, each DR_W bits wide.
//  - Per selected channel: captures a status word, shifts it via tdi/tdo, and commits the shifted value on Update-DR.
//  - Adds multi-channel DR support and an IR status readback to the node's raw state outputs.
//  - Sits in the tck domain between the node and the debug/config logic.

---
 rtl/vjtag_dr_bank_if.sv | 32 +++
 rtl/vjtag_dr_bank.sv | 98 +++++++++
 tb/tb_vjtag_dr_bank.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vjtag_dr_bank_if.sv
// Bundle of node-side signals for vjtag_dr_bank: JTAG state strobes, serial data, IR and channel data.
// upd_valid is a one-tck strobe with no ready; the consumer samples upd_data on the cycle it is high.
interface vjtag_dr_bank_if #(
    parameter int IR_W   = 2,
    parameter int NUM_CH = 3,
    parameter int DR_W   = 8
);
    logic                   tdi;
    logic                   tdo;
    logic [IR_W-1:0]        ir_in;
    logic [IR_W-1:0]        ir_out;
    logic                   virtual_state_cdr;
    logic                   virtual_state_sdr;
    logic                   virtual_state_udr;
    logic                   virtual_state_cir;
    logic                   virtual_state_uir;
    logic [NUM_CH*DR_W-1:0] cap_data;
    logic [NUM_CH*DR_W-1:0] upd_data;
    logic [NUM_CH-1:0]      upd_valid;

    modport master (
        output tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
               virtual_state_cir, virtual_state_uir, cap_data,
        input  tdo, ir_out, upd_data, upd_valid
    );

    modport slave (
        input  tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
               virtual_state_cir, virtual_state_uir, cap_data,
        output tdo, ir_out, upd_data, upd_valid
    );
endinterface

// File: rtl/vjtag_dr_bank.sv
// Virtual-JTAG DR bank: ir_in picks one of NUM_CH capture/shift/update registers, codes >= NUM_CH bypass.
// Define VJTAG_DR_PARITY_EN to add an even-parity bit per register and a sticky error flag on ir_out.
module vjtag_dr_bank #(
    parameter int IR_W   = 2,
    parameter int NUM_CH = 3,
    parameter int DR_W   = 8
) (
    input logic            tck,
    input logic            rst_n,
    vjtag_dr_bank_if.slave bus
);
`ifdef VJTAG_DR_PARITY_EN
    localparam int SR_W = DR_W + 1;
`else
    localparam int SR_W = DR_W;
`endif

    logic [SR_W-1:0]        sr;
    logic [IR_W-1:0]        sel_q;
    logic                   byp_sel_q;
    logic                   byp_q;
    logic                   err_q;
    logic [IR_W-1:0]        ir_out_q;
    logic [NUM_CH*DR_W-1:0] upd_data_q;
    logic [NUM_CH-1:0]      upd_valid_q;

    logic [DR_W-1:0]        cap_word;
    logic [SR_W-1:0]        cap_sr;
    logic                   ir_is_byp;
    logic                   sr_ok;
    logic                   upd_hit;
    logic                   commit;
    logic                   par_err;

    // Capture uses the code presented in the same Capture-DR cycle that latches sel_q.
    always_comb begin
        cap_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ir_in == IR_W'(i)) cap_word = bus.cap_data[i*DR_W +: DR_W];
        end
    end

    assign ir_is_byp = (int'(bus.ir_in) >= NUM_CH);

`ifdef VJTAG_DR_PARITY_EN
    assign cap_sr = {^cap_word, cap_word};
    assign sr_ok  = ~^sr;
`else
    assign cap_sr = cap_word;
    assign sr_ok  = 1'b1;
`endif

    // Update-DR only counts when neither higher-priority state is asserted.
    assign upd_hit = bus.virtual_state_udr & ~bus.virtual_state_cdr & ~bus.virtual_state_sdr & ~byp_sel_q;
    assign commit  = upd_hit & sr_ok;
    assign par_err = upd_hit & ~sr_ok;

    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            sel_q       <= '0;
            byp_sel_q   <= 1'b0;
            byp_q       <= 1'b0;
            err_q       <= 1'b0;
            ir_out_q    <= '0;
            upd_data_q  <= '0;
            upd_valid_q <= '0;
        end else begin
            upd_valid_q <= '0;
            if (bus.virtual_state_cdr) begin
                sel_q     <= bus.ir_in;
                byp_sel_q <= ir_is_byp;
                if (ir_is_byp) byp_q <= 1'b0;
                else           sr    <= cap_sr;
            end else if (bus.virtual_state_sdr) begin
                if (byp_sel_q) byp_q <= bus.tdi;
                else           sr    <= {bus.tdi, sr[SR_W-1:1]};
            end else if (commit) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel_q == IR_W'(i)) begin
                        upd_data_q[i*DR_W +: DR_W] <= sr[DR_W-1:0];
                        upd_valid_q[i]             <= 1'b1;
                    end
                end
            end

            if (bus.virtual_state_uir) err_q <= 1'b0;
            else if (par_err)          err_q <= 1'b1;

            if (bus.virtual_state_cir) ir_out_q <= IR_W'(err_q);
        end
    end

    assign bus.tdo       = byp_sel_q ? byp_q : sr[0];
    assign bus.ir_out    = ir_out_q;
    assign bus.upd_data  = upd_data_q;
    assign bus.upd_valid = upd_valid_q;
endmodule

// File: tb/tb_vjtag_dr_bank.sv
// Randomised bench for vjtag_dr_bank: bit-stream reference model feeding tdo and commit scoreboards.
// Honours VJTAG_DR_PARITY_EN the same way as the design.
module tb_vjtag_dr_bank;
    localparam int IR_W   = 2;
    localparam int NUM_CH = 3;
    localparam int DR_W   = 8;
    localparam int CW     = NUM_CH * DR_W;
    localparam int W      = NUM_CH + CW;
`ifdef VJTAG_DR_PARITY_EN
    localparam int SR_W = DR_W + 1;
    localparam bit PAR  = 1'b1;
`else
    localparam int SR_W = DR_W;
    localparam bit PAR  = 1'b0;
`endif

    // clock / reset
    logic tck   = 1'b0;
    logic rst_n = 1'b0;
    always #5 tck = ~tck;

    vjtag_dr_bank_if #(.IR_W(IR_W), .NUM_CH(NUM_CH), .DR_W(DR_W)) bus ();
    vjtag_dr_bank #(.IR_W(IR_W), .NUM_CH(NUM_CH), .DR_W(DR_W)) dut (
        .tck  (tck),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // scoreboard state
    logic [W-1:0]    exp_q[$];
    bit              exp_tdo_q[$];
    logic [DR_W-1:0] model_upd[NUM_CH];
    bit              model_err;
    int              total = 0;
    int              bad   = 0;
    bit              mon_tdo;
    logic [W-1:0]    mon_exp;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [W-1:0] model_vec(input logic [NUM_CH-1:0] v);
        logic [W-1:0] r;
        r = '0;
        r[W-1 -: NUM_CH] = v;
        for (int i = 0; i < NUM_CH; i++) r[i*DR_W +: DR_W] = model_upd[i];
        return r;
    endfunction

    // monitor: tdo is checked on every Shift-DR cycle, commits whenever upd_valid is high
    always @(negedge tck) begin
        if (rst_n && bus.virtual_state_sdr) begin
            if (exp_tdo_q.size() == 0) begin
                total++; bad++;
                $display("FAIL tdo_unexpected: got=%0b want=none", bus.tdo);
            end else begin
                mon_tdo = exp_tdo_q.pop_front();
                check("tdo", W'(bus.tdo), W'(mon_tdo));
            end
        end
        if (bus.upd_valid != '0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL upd_valid_spurious: got=%0b want=0", bus.upd_valid);
            end else begin
                mon_exp = exp_q.pop_front();
                check("commit", {bus.upd_valid, bus.upd_data}, mon_exp);
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic run_dr(input int code, input logic [CW-1:0] cap, input int n,
                          input logic [63:0] tdi_bits, input int swap_at, input int swap_code);
        bit              stream[$];
        logic [DR_W-1:0] cw;
        logic [SR_W-1:0] fin;
        int              ones;
        bit              byp;
        byp = (code >= NUM_CH);
        bus.cap_data = cap;
        bus.ir_in    = IR_W'(code);
        cw           = '0;
        if (byp) stream.push_back(1'b0);
        else begin
            cw = cap[code*DR_W +: DR_W];
            for (int i = 0; i < DR_W; i++) stream.push_back(cw[i]);
            if (PAR) stream.push_back(^cw);
        end
        for (int i = 0; i < n; i++) stream.push_back(tdi_bits[i]);
        for (int i = 0; i < n; i++) exp_tdo_q.push_back(stream[i]);

        bus.virtual_state_cdr = 1'b1;
        tick();
        bus.virtual_state_cdr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == swap_at) bus.ir_in = IR_W'(swap_code);
            bus.virtual_state_sdr = 1'b1;
            bus.tdi               = tdi_bits[i];
            tick();
        end
        bus.virtual_state_sdr = 1'b0;

        if (!byp) begin
            fin  = '0;
            ones = 0;
            for (int i = 0; i < SR_W; i++) begin
                fin[i] = stream[n+i];
                ones  += int'(stream[n+i]);
            end
            if (!PAR || (ones % 2 == 0)) begin
                model_upd[code] = fin[DR_W-1:0];
                exp_q.push_back(model_vec(NUM_CH'(1) << code));
            end else begin
                model_err = 1'b1;
            end
        end
        bus.virtual_state_udr = 1'b1;
        tick();
        bus.virtual_state_udr = 1'b0;
        tick();
    endtask

    task automatic do_cir();
        bus.virtual_state_cir = 1'b1;
        tick();
        bus.virtual_state_cir = 1'b0;
        check("ir_out", W'(bus.ir_out), W'(model_err));
    endtask

    task automatic do_uir();
        bus.virtual_state_uir = 1'b1;
        tick();
        bus.virtual_state_uir = 1'b0;
        model_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdo"}, W'(bus.tdo), '0);
        check({tag, "_ir_out"}, W'(bus.ir_out), '0);
        check({tag, "_upd_valid"}, W'(bus.upd_valid), '0);
        check({tag, "_upd_data"}, W'(bus.upd_data), '0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) model_upd[i] = '0;
        model_err = 1'b0;
        exp_tdo_q.delete();
    endtask

    task automatic reset_mid_shift();
        logic [DR_W-1:0] cw;
        bus.cap_data = CW'($urandom());
        bus.ir_in    = IR_W'(1);
        cw           = bus.cap_data[DR_W +: DR_W];
        for (int i = 0; i < 3; i++) exp_tdo_q.push_back(cw[i]);
        bus.virtual_state_cdr = 1'b1;
        tick();
        bus.virtual_state_cdr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.virtual_state_sdr = 1'b1;
            bus.tdi               = 1'($urandom_range(0, 1));
            tick();
        end
        bus.virtual_state_sdr = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid_reset");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("post_reset_data", W'(bus.upd_data), '0);
    endtask

    // main sequence
    logic [63:0] rt;
    int          rcode;
    int          rn;
    int          rswap;

    initial begin
        bus.tdi               = 1'b0;
        bus.ir_in             = '0;
        bus.virtual_state_cdr = 1'b0;
        bus.virtual_state_sdr = 1'b0;
        bus.virtual_state_udr = 1'b0;
        bus.virtual_state_cir = 1'b0;
        bus.virtual_state_uir = 1'b0;
        bus.cap_data          = '0;
        model_reset();

        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        tick();

        // channel 1: capture A5, shift in 3C
        run_dr(1, {8'h00, 8'hA5, 8'h00}, 8, 64'h3C, -1, 0);
        // bypass: shift 1,1,0 and confirm nothing moves
        run_dr(3, CW'($urandom()), 3, 64'h3, -1, 0);
        check("bypass_hold", {NUM_CH'(0), bus.upd_data}, model_vec('0));
        // select changes mid-shift: commit still lands on channel 0
        run_dr(0, CW'($urandom()), 8, {32'h0, $urandom()}, 3, 2);
        // short shift leaves capture bits in the low positions
        run_dr(2, {8'h00, 8'h5A, 8'hC3}, 4, 64'hF, -1, 0);
        do_cir();

`ifdef VJTAG_DR_PARITY_EN
        // nine bits with odd parity: rejected, error sticks until Update-IR
        run_dr(1, CW'($urandom()), 9, 64'h001, -1, 0);
        do_cir();
        do_uir();
        do_cir();
`endif

        for (int k = 0; k < 24; k++) begin
            rcode = $urandom_range(0, 3);
            rn    = $urandom_range(1, 12);
            rt    = {$urandom(), $urandom()};
            rswap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            run_dr(rcode, CW'($urandom()), rn, rt, rswap, $urandom_range(0, 3));
            if (k % 6 == 5) begin
                do_cir();
                do_uir();
            end
        end

        reset_mid_shift();
        run_dr(2, CW'($urandom()), DR_W, {32'h0, $urandom()}, -1, 0);

        tick();
        tick();
        check("commit_pending", W'(exp_q.size()), '0);
        check("tdo_pending", W'(exp_tdo_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
